dcpu_bus_timer: RTL
===================

Name: dcpu_bus_timer

Overview:
- Memory-mapped bus responder on the dcpu data/instruction bus: 16-bit addr/data, chip select, write enable, ack handshake.
- Implements a prescaled 16-bit down-counter timer with reload, one-shot or auto-reload mode, and a level interrupt that drives the CPU irq input.
- Serves as the responder-side reference implementation of the bus handshake for future peripherals.

Parameters:
- BASE, 16'hFF00, base address; the block decodes i_addr[15:3] == BASE[15:3] (8-word window).
- WAIT, 0, extra wait cycles before ack (0..15).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_addr  in  16  bus address from CPU.
- i_dat  in  16  write data from CPU.
- o_dat  out  16  read data to CPU; valid while o_ack=1, otherwise 0.
- i_we  in  1  write strobe; qualified by i_cs.
- i_cs  in  1  bus cycle request; held by CPU until ack.
- o_ack  out  1  one-cycle access completion.
- o_irq  out  1  interrupt request, level.

Behaviour:
- Reset (async): state IDLE; o_ack=0, o_dat=0, o_irq=0; CTRL, STATUS, PRESCALE, RELOAD, COUNT, prescaler counter and wait counter all 0.
- Select: sel = i_cs & address match. Non-matching cycles are ignored, with no ack.
- Register map (offset i_addr[2:0]):
  - 0 CTRL: [0] EN, [1] AUTO, [2] IE; other bits read 0.
  - 1 STATUS: [0] EXP; writing 1 clears it, writing 0 has no effect.
  - 2 PRESCALE.
  - 3 RELOAD.
  - 4 COUNT: reads the live value; a write loads the counter.
  - 5..7: reads return 0, writes are ignored, ack is still given.
- Handshake FSM (IDLE, WAIT, ACK):
  - IDLE, sel=1: if WAIT=0, perform the access at this edge and go to ACK. Otherwise load wcnt=WAIT and go to WAIT.
  - WAIT: if sel drops, go to IDLE with no access (abort). If wcnt=1, perform the access and go to ACK. Otherwise decrement wcnt.
  - ACK: o_ack=1 for exactly one cycle; go to IDLE unconditionally. A sel still high in the next cycle is a new access.
  - Latency: o_ack is high in cycle WAIT+1, counting the first cycle sel is seen as cycle 0.
  - Back-to-back accesses: one idle cycle between acks.
- Perform access:
  - Write (i_we=1): update the register at that edge.
  - Read: snapshot the register into o_dat at that edge. o_dat returns to 0 when leaving ACK.
- Prescaler:
  - Counts 0..PRESCALE while EN=1.
  - tick = (pcnt == PRESCALE); pcnt wraps to 0 on tick.
  - PRESCALE=0 gives a tick every clock.
  - A write that sets EN from 0 to 1 clears pcnt.
  - When EN=0, pcnt holds 0 and there are no ticks.
- Counter, on tick:
  - If COUNT != 0, decrement COUNT.
  - If COUNT == 0: set EXP. If AUTO=1, COUNT <= RELOAD. Otherwise EN <= 0 (one-shot) and COUNT stays 0.
- o_irq: registered EXP & IE, updated every clock, so it is 1 cycle behind the flag.
- Simultaneous events:
  - COUNT write and tick in the same cycle: the write wins.
  - STATUS clear and expiry in the same cycle: the set wins.
  - CTRL write and one-shot EN auto-clear in the same cycle: the write wins.
- Arithmetic is unsigned 16-bit. No wrap below 0; the zero case is handled by the expiry rule above.
- Reset mid-access: FSM returns to IDLE immediately and o_ack drops asynchronously. The CPU re-issues the access after reset.

Test Plan:
- WAIT=0, BASE=FF00: write FF03=0x0005 then read FF03 -> o_ack high 1 cycle after i_cs for each access, o_dat=0x0005 during the ack cycle, 0 otherwise. Read of FF05 -> 0x0000 with ack. Access to FE00 -> no ack.
- WAIT=3: hold i_cs on a read -> o_ack in cycle 4 only. Drop i_cs after 2 cycles -> no ack, no register change.
- PRESCALE=1, COUNT=3, CTRL=0x5 (EN, IE, one-shot) -> COUNT steps 3,2,1,0 every 2 clocks. At the next tick EXP=1 and EN=0, o_irq=1 one cycle later. Write STATUS=1 -> o_irq=0.
- AUTO: RELOAD=2, COUNT=0, PRESCALE=0, CTRL=0x3 -> EXP set on the first tick, then COUNT sequence 2,1,0,2,… with EXP re-asserting every 3 clocks.
- STATUS=1 written in the same cycle as an expiry -> EXP stays 1. COUNT=0x1234 written in a tick cycle -> COUNT=0x1234 next cycle.
- Assert i_reset while in WAIT, with an armed timer -> o_ack=0, o_irq=0, all registers 0 immediately, without a clock edge.

Source files
------------

// File: rtl/dcpu_bus_timer.sv
// Prescaled 16-bit down-counter timer on the dcpu bus with level irq; o_ack arrives WAIT+1 cycles after select.
// The CPU holds i_cs until o_ack; dropping it during the wait phase aborts the access with no side effects.
module dcpu_bus_timer #(
  parameter logic [15:0] BASE = 16'hFF00,
  parameter int unsigned WAIT = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_dat,
  output logic [15:0] o_dat,
  input  logic        i_we,
  input  logic        i_cs,
  output logic        o_ack,
  output logic        o_irq
);
  localparam logic [3:0] WAIT_CNT = WAIT[3:0];

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        exp_q, exp_d;
  logic        irq_q, irq_d;
  logic [15:0] pre_q, pre_d;
  logic [15:0] rel_q, rel_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [15:0] dat_q, dat_d;

  logic        sel, access, wr, tick, expire;
  logic [15:0] rdata;

  assign sel = i_cs && (i_addr[15:3] == BASE[15:3]);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel) begin
          if (WAIT_CNT == 4'd0) begin
            access  = 1'b1;
            state_d = S_ACK;
          end else begin
            wcnt_d  = WAIT_CNT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!sel) begin
          state_d = S_IDLE;
        end else if (wcnt_q == 4'd1) begin
          access  = 1'b1;
          state_d = S_ACK;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata = 16'd0;
    case (i_addr[2:0])
      3'd0:    rdata = {13'd0, ctrl_q};
      3'd1:    rdata = {15'd0, exp_q};
      3'd2:    rdata = pre_q;
      3'd3:    rdata = rel_q;
      3'd4:    rdata = cnt_q;
      default: rdata = 16'd0;
    endcase
  end

  always_comb begin
    wr     = access && i_we;
    tick   = ctrl_q[0] && (pcnt_q == pre_q);
    expire = tick && (cnt_q == 16'd0);
    ctrl_d = ctrl_q;
    exp_d  = exp_q;
    pre_d  = pre_q;
    rel_d  = rel_q;
    cnt_d  = cnt_q;
    dat_d  = dat_q;

    if (tick) begin
      if (cnt_q != 16'd0)  cnt_d     = cnt_q - 16'd1;
      else if (ctrl_q[1])  cnt_d     = rel_q;
      else                 ctrl_d[0] = 1'b0;
    end

    // Bus writes are applied after the timer update so they take priority.
    if (wr) begin
      case (i_addr[2:0])
        3'd0:    ctrl_d = i_dat[2:0];
        3'd1:    if (i_dat[0]) exp_d = 1'b0;
        3'd2:    pre_d = i_dat;
        3'd3:    rel_d = i_dat;
        3'd4:    cnt_d = i_dat;
        default: ;
      endcase
    end
    if (expire) exp_d = 1'b1;

    // Enabling from idle restarts the prescale period; disabled holds it at 0.
    if (!ctrl_d[0] || !ctrl_q[0] || tick) pcnt_d = 16'd0;
    else                                  pcnt_d = pcnt_q + 16'd1;

    if (state_q == S_ACK)   dat_d = 16'd0;
    if (access && !i_we)    dat_d = rdata;

    irq_d = exp_q && ctrl_q[2];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      ctrl_q  <= 3'd0;
      exp_q   <= 1'b0;
      irq_q   <= 1'b0;
      pre_q   <= 16'd0;
      rel_q   <= 16'd0;
      cnt_q   <= 16'd0;
      pcnt_q  <= 16'd0;
      dat_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ctrl_q  <= ctrl_d;
      exp_q   <= exp_d;
      irq_q   <= irq_d;
      pre_q   <= pre_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      dat_q   <= dat_d;
    end
  end

  assign o_ack = (state_q == S_ACK);
  assign o_dat = dat_q;
  assign o_irq = irq_q;

endmodule
